data_sram_responder: RTL and testbench

Responder (slave) end of the SRAM-like data interface driven by the MEM stage. It accepts requests with `data_addr_ok` and commits writes into a local byte-enabled word array. It returns each response in order with a one-cycle `data_ok` pulse a fixed `LATENCY` cycles after acceptance. It serves as on-chip data RAM for standalone CPU simulation and as the latency model for MEM-stage stall/clear verification.

---
 rtl/data_sram_responder.sv | 130 +++++++++++++
 tb/tb_data_sram_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Responder end of the SRAM-like data interface: byte-enabled word RAM with an
// in-order response queue. `DATA_SRAM_RESP_STALL_EN adds LFSR request back-pressure.
module data_sram_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [2:0]       AGE_MAX  = 3'(LATENCY);
    localparam logic [2:0]       AGE_PRE  = 3'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

    logic [31:0]           r_mem [0:(2**ADDR_WIDTH)-1];
    logic [31:0]           r_q_rdata [0:OUTSTANDING-1];
    logic [2:0]            r_q_age   [0:OUTSTANDING-1];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_data_ok;
    logic [31:0]           r_rdata;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]            w_be;
    logic                  w_stall;
    logic                  w_accept;
    logic                  w_head_mature;
    logic                  w_fresh_mature;
    logic                  w_retire;
    logic [31:0]           w_fresh_rdata;
    logic                  w_unused;

    assign w_idx    = data_addr[ADDR_WIDTH+1:2];
    assign w_unused = &{1'b0, data_addr[31:ADDR_WIDTH+2]};

    always_comb begin
        w_be = 4'b0000;
        case (data_size)
            2'd0: w_be = 4'b0001 << data_addr[1:0];
            2'd1: begin
                if (data_addr[1:0] == 2'b00)      w_be = 4'b0011;
                else if (data_addr[1:0] == 2'b10) w_be = 4'b1100;
            end
            default: begin
                if (data_addr[1:0] == 2'b00)      w_be = 4'b1111;
            end
        endcase
    end

`ifdef DATA_SRAM_RESP_STALL_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_lfsr <= 8'hA5;
        else         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign data_addr_ok = resetn && (r_count < CNT_MAX) && !w_stall;
    assign w_accept     = data_req && data_addr_ok;

    // Stored entries retire on the edge their age reaches LATENCY; with
    // LATENCY=1 a request into an empty queue retires on its own accept edge.
    assign w_head_mature  = (r_count != '0) && (r_q_age[r_rptr] == AGE_PRE);
    assign w_fresh_mature = (LATENCY == 1) && w_accept && (r_count == '0);
    assign w_retire       = w_head_mature || w_fresh_mature;
    assign w_fresh_rdata  = data_wr ? 32'h0 : r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (w_accept && data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= data_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (w_accept && (r_wptr == PTR_W'(i))) begin
                r_q_age[i]   <= 3'd1;
                r_q_rdata[i] <= w_fresh_rdata;
            end else if (r_q_age[i] != AGE_MAX) begin
                r_q_age[i]   <= r_q_age[i] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_data_ok <= 1'b0;
            r_rdata   <= 32'h0;
        end else begin
            r_data_ok <= w_retire;
            if (w_head_mature)       r_rdata <= r_q_rdata[r_rptr];
            else if (w_fresh_mature) r_rdata <= w_fresh_rdata;
            else                     r_rdata <= 32'h0;

            if (w_accept) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_W'(1);
            if (w_retire) r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_W'(1);

            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_rdata   = r_rdata;
    assign data_data_ok = r_data_ok;
endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances (L2/O2, L3/O1, L1/O1)
// sharing address/data buses, each with its own request line.
module tb_data_sram_responder;
    logic        clk;
    logic        resetn;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        req  [3];
    logic [31:0] rdat [3];
    logic        aok  [3];
    logic        dok  [3];

    int n_cmp  = 0;
    int n_mism = 0;

    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(2), .OUTSTANDING(2)) u_dut (
        .clk(clk), .resetn(resetn), .data_req(req[0]), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(rdat[0]), .data_addr_ok(aok[0]), .data_data_ok(dok[0]));

    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(3), .OUTSTANDING(1)) u_dut_slow (
        .clk(clk), .resetn(resetn), .data_req(req[1]), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(rdat[1]), .data_addr_ok(aok[1]), .data_data_ok(dok[1]));

    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(1), .OUTSTANDING(1)) u_dut_fast (
        .clk(clk), .resetn(resetn), .data_req(req[2]), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(rdat[2]), .data_addr_ok(aok[2]), .data_data_ok(dok[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mism++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request to instance sel, then wait for its response and check it.
    task automatic issue(input int sel, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input int lat, input string tag);
        int waits;
        data_wr    = wr;
        data_size  = size;
        data_addr  = addr;
        data_wdata = wdata;
        req[sel]   = 1'b1;
        waits = 0;
        while (!aok[sel] && waits < 20) begin
            step();
            waits++;
        end
        check($sformatf("%s_addr_ok", tag), 32'(aok[sel]), 32'd1);
        step();
        req[sel] = 1'b0;
        waits = 0;
        while (!dok[sel] && waits < 20) begin
            step();
            waits++;
        end
        check($sformatf("%s_latency", tag), 32'(waits), 32'(lat - 1));
        check($sformatf("%s_rdata", tag), rdat[sel], exp_rdata);
        $display("txn %s dut=%0d wr=%0d size=%0d addr=%h wdata=%h rdata=%h wait=%0d",
                 tag, sel, wr, size, addr, wdata, rdat[sel], waits);
        step();
    endtask

    logic [31:0] b2b_tbl  [6] = '{32'h11110000, 32'h22220001, 32'h33330002,
                                  32'h44440003, 32'h55550004, 32'h66660005};
    logic [31:0] slow_tbl [3] = '{32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};

    initial begin
        int acc;
        resetn     = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_addr_ok", 32'(aok[0]), 32'd0);
        check("reset_data_ok", 32'(dok[0]), 32'd0);
        check("reset_rdata", rdat[0], 32'h0);
        resetn = 1'b1;
        #1;
        check("post_reset_addr_ok", 32'(aok[0]), 32'd1);
        step();

        // Word write then read, LATENCY=2
        issue(0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 2, "wr_word");
        issue(0, 1'b0, 2'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2, "rd_word");

        // Byte / half lanes, misaligned half, size 3 as word
        issue(0, 1'b1, 2'd2, 32'h200, 32'h00000000, 32'h0, 2, "wr_zero");
        issue(0, 1'b1, 2'd0, 32'h202, 32'h5A5A5A5A, 32'h0, 2, "wr_byte");
        issue(0, 1'b1, 2'd1, 32'h200, 32'h12341234, 32'h0, 2, "wr_half");
        issue(0, 1'b0, 2'd2, 32'h200, 32'h0, 32'h005A1234, 2, "rd_lanes");
        issue(0, 1'b1, 2'd1, 32'h201, 32'hFFFFFFFF, 32'h0, 2, "wr_misalign");
        issue(0, 1'b0, 2'd0, 32'h203, 32'h0, 32'h005A1234, 2, "rd_unchanged");
        issue(0, 1'b1, 2'd3, 32'h400, 32'hCAFEF00D, 32'h0, 2, "wr_size3");
        issue(0, 1'b0, 2'd2, 32'h400, 32'h0, 32'hCAFEF00D, 2, "rd_size3");

        // Aliasing modulo 16 KiB
        issue(0, 1'b1, 2'd2, 32'h00004010, 32'h11111111, 32'h0, 2, "wr_alias");
        issue(0, 1'b0, 2'd2, 32'h00000010, 32'h0, 32'h11111111, 2, "rd_alias");

        // Read accepted right behind a write still awaiting its response
        data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h510; data_wdata = 32'hA5A50F0F;
        req[0] = 1'b1;
        step();
        data_wr = 1'b0;
        step();
        req[0] = 1'b0;
        check("raw_wr_ok", 32'(dok[0]), 32'd1);
        check("raw_wr_rdata", rdat[0], 32'h0);
        step();
        check("raw_rd_ok", 32'(dok[0]), 32'd1);
        check("raw_rd_rdata", rdat[0], 32'hA5A50F0F);
        $display("txn raw_hazard dut=0 addr=00000510 rdata=%h", rdat[0]);
        step();

        // Back-to-back reads, OUTSTANDING=2 LATENCY=2
        for (int i = 0; i < 6; i++)
            issue(0, 1'b1, 2'd2, 32'h700 + 32'(4 * i), b2b_tbl[i], 32'h0, 2, "b2b_fill");
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                data_wr = 1'b0; data_addr = 32'h700 + 32'(4 * i); req[0] = 1'b1;
                check($sformatf("b2b_addr_ok%0d", i), 32'(aok[0]), 32'd1);
            end else begin
                req[0] = 1'b0;
            end
            step();
            if (i == 0) begin
                check("b2b_first_idle", 32'(dok[0]), 32'd0);
            end else begin
                check($sformatf("b2b_ok%0d", i - 1), 32'(dok[0]), 32'd1);
                check($sformatf("b2b_rdata%0d", i - 1), rdat[0], b2b_tbl[i - 1]);
                $display("txn b2b read %0d rdata=%h", i - 1, rdat[0]);
            end
        end
        step();
        check("b2b_drained", 32'(dok[0]), 32'd0);

        // Full queue, OUTSTANDING=1 LATENCY=3: accepts every third cycle
        for (int i = 0; i < 3; i++)
            issue(1, 1'b1, 2'd2, 32'h800 + 32'(4 * i), slow_tbl[i], 32'h0, 3, "slow_fill");
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            data_wr   = 1'b0;
            data_addr = 32'h800 + 32'(4 * acc);
            req[1]    = (acc < 3);
            check($sformatf("slow_addr_ok_c%0d", c), 32'(aok[1]), 32'((c % 3) == 0));
            check($sformatf("slow_data_ok_c%0d", c), 32'(dok[1]), 32'((c % 3) == 0 && c > 0));
            if (dok[1]) begin
                check($sformatf("slow_rdata_c%0d", c), rdat[1], slow_tbl[(c / 3) - 1]);
                $display("txn slow read %0d rdata=%h", (c / 3) - 1, rdat[1]);
            end
            if (req[1] && aok[1]) acc++;
            step();
        end
        req[1] = 1'b0;

        // LATENCY=1: response in the cycle right after acceptance
        issue(2, 1'b1, 2'd2, 32'h40, 32'h0F1E2D3C, 32'h0, 1, "fast_wr");
        issue(2, 1'b0, 2'd2, 32'h40, 32'h0, 32'h0F1E2D3C, 1, "fast_rd");
        for (int i = 0; i < 2; i++) begin
            data_wr = 1'b0; data_addr = 32'h40; req[2] = 1'b1;
            check($sformatf("fast_b2b_addr_ok%0d", i), 32'(aok[2]), 32'd1);
            step();
            check($sformatf("fast_b2b_ok%0d", i), 32'(dok[2]), 32'd1);
            check($sformatf("fast_b2b_rdata%0d", i), rdat[2], 32'h0F1E2D3C);
        end
        req[2] = 1'b0;
        step();

        // Reset mid-flight
        issue(0, 1'b1, 2'd2, 32'h600, 32'h600DDA7A, 32'h0, 2, "pre_reset_wr");
        data_wr = 1'b0; data_addr = 32'h600; req[0] = 1'b1;
        step();
        step();
        req[0] = 1'b0;
        check("pre_reset_ok", 32'(dok[0]), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_reset_data_ok", 32'(dok[0]), 32'd0);
        check("mid_reset_addr_ok", 32'(aok[0]), 32'd0);
        check("mid_reset_rdata", rdat[0], 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_reset_quiet%0d", i), 32'(dok[0]), 32'd0);
        end
        check("post_reset_addr_ok2", 32'(aok[0]), 32'd1);
        issue(0, 1'b0, 2'd2, 32'h600, 32'h0, 32'h600DDA7A, 2, "post_reset_rd");
        issue(1, 1'b0, 2'd2, 32'h804, 32'h0, 32'hC0DE0002, 3, "post_reset_slow_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
